// File: rtl/des_subkey_store.sv
// des_subkey_store: applies PC-2 to each rotated C/D pair and buffers the 16 DES subkeys,
// returning them by round number in forward (encrypt) or reversed (decrypt) order.
module des_subkey_store #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        cd_valid,
  input  logic [27:0] c_in,
  input  logic [27:0] d_in,
  input  logic        rd_req,
  input  logic        rd_mode,
  input  logic [3:0]  rd_round,
  output logic [47:0] subkey_out,
  output logic        subkey_valid,
  output logic        rd_err,
  output logic        keys_ready,
  output logic [4:0]  write_count,
  output logic        overflow
);
  localparam int T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
                            26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
                            51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  logic [47:0] slot [NUM_ROUNDS];
  logic [55:0] cd;
  logic [47:0] pc2;
  logic        full, wr;
  logic [3:0]  sel;
  assign cd   = {c_in, d_in};
  assign full = write_count == 5'(NUM_ROUNDS);
  // X on c_in/d_in while cd_valid is low is harmless: wr gates every slot write
  assign wr   = cd_valid && !clear && !full;
  assign sel  = rd_mode ? 4'd15 - rd_round : rd_round;
  always_comb begin
    pc2 = '0;
    for (int j = 0; j < 48; j++) pc2[47-j] = cd[56-T[j]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROUNDS; i++) slot[i] <= '0;
      subkey_out   <= '0;
      subkey_valid <= 1'b0;
      rd_err       <= 1'b0;
      keys_ready   <= 1'b0;
      write_count  <= '0;
      overflow     <= 1'b0;
    end else if (clear) begin
      subkey_valid <= 1'b0;
      rd_err       <= 1'b0;
      keys_ready   <= 1'b0;
      write_count  <= '0;
      overflow     <= 1'b0;
    end else begin
      if (wr) begin
        slot[write_count[3:0]] <= pc2;
        write_count            <= write_count + 5'd1;
        keys_ready             <= write_count == 5'(NUM_ROUNDS - 1);
      end
      if (cd_valid && full) overflow <= 1'b1;
      subkey_valid <= rd_req && keys_ready;
      rd_err       <= rd_req && !keys_ready;
      if (rd_req && keys_ready) subkey_out <= slot[sel];
    end
  end
endmodule

// File: tb/tb_des_subkey_store.sv
// tb_des_subkey_store: randomized checks of des_subkey_store against a PC-2/key-schedule model.
module tb_des_subkey_store;
  logic        clk = 1'b0;
  logic        rst_n, clear, cd_valid, rd_req, rd_mode;
  logic [27:0] c_in, d_in;
  logic [3:0]  rd_round;
  logic [47:0] subkey_out;
  logic        subkey_valid, rd_err, keys_ready, overflow;
  logic [4:0]  write_count;
  int          total = 0, bad = 0;
  int          tt [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
                           26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
                           51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  logic [27:0] kc [16], kd [16];
  logic [47:0] mdl [16];

  des_subkey_store dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cd_valid(cd_valid), .c_in(c_in), .d_in(d_in),
    .rd_req(rd_req), .rd_mode(rd_mode), .rd_round(rd_round), .subkey_out(subkey_out),
    .subkey_valid(subkey_valid), .rd_err(rd_err), .keys_ready(keys_ready),
    .write_count(write_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] pc2_ref(input logic [27:0] c, input logic [27:0] d);
    logic [56:1] cdv;
    logic [48:1] k;
    cdv = {c, d};
    for (int j = 1; j <= 48; j++) k[49-j] = cdv[57-tt[j-1]];
    return k;
  endfunction

  task automatic build_schedule();
    int sh [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    logic [27:0] c, d;
    c = 28'hF0CCAAF;
    d = 28'h556678F;
    for (int r = 0; r < 16; r++) begin
      repeat (sh[r]) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      kc[r] = c;
      kd[r] = d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cd_valid = 0; rd_req = 0; clear = 0; c_in = 'x; d_in = 'x;
  endtask

  task automatic test_reset();
    rst_n = 0; rd_mode = 0; rd_round = 0;
    idle_inputs();
    #12;
    total++; if ({subkey_out, subkey_valid, rd_err, keys_ready, write_count, overflow} !== 57'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {subkey_out, subkey_valid, rd_err, keys_ready, write_count, overflow}); end
    rst_n = 1;
    step();
    rd_req = 1; rd_round = 0;
    step();
    rd_req = 0;
    total++; if (rd_err !== 1'b1) begin bad++; $display("FAIL early_rd_err got=%b exp=1", rd_err); end
    total++; if (subkey_valid !== 1'b0) begin bad++; $display("FAIL early_valid got=%b exp=0", subkey_valid); end
    total++; if (keys_ready !== 1'b0 || write_count !== 5'd0) begin bad++; $display("FAIL early_state got=%b/%0d exp=0/0", keys_ready, write_count); end
    step();
    total++; if (rd_err !== 1'b0) begin bad++; $display("FAIL rd_err_pulse got=%b exp=0", rd_err); end
  endtask

  task automatic test_fill_known();
    for (int r = 0; r < 16; r++) begin
      cd_valid = 1; c_in = kc[r]; d_in = kd[r];
      mdl[r] = pc2_ref(kc[r], kd[r]);
      if (r == 15) begin rd_req = 1; rd_mode = 0; rd_round = 0; end
      step();
      idle_inputs();
      if (r == 0) begin
        total++; if (write_count !== 5'd1) begin bad++; $display("FAIL first_write_count got=%0d exp=1", write_count); end
      end
      if (r == 14) begin
        total++; if (keys_ready !== 1'b0 || write_count !== 5'd15) begin bad++; $display("FAIL pre_full got=%b/%0d exp=0/15", keys_ready, write_count); end
      end
    end
    total++; if (keys_ready !== 1'b1 || write_count !== 5'd16) begin bad++; $display("FAIL full got=%b/%0d exp=1/16", keys_ready, write_count); end
    total++; if (rd_err !== 1'b1 || subkey_valid !== 1'b0) begin bad++; $display("FAIL read_on_16th got=err%b/v%b exp=1/0", rd_err, subkey_valid); end
  endtask

  task automatic test_read_known();
    logic [47:0] exp_k;
    rd_req = 1; rd_mode = 0; rd_round = 0;
    step();
    total++; if (subkey_out !== 48'h1B02EFFC7072 || subkey_valid !== 1'b1) begin bad++; $display("FAIL enc_r0 got=%h/%b exp=1b02effc7072/1", subkey_out, subkey_valid); end
    rd_mode = 1; rd_round = 0;
    step();
    total++; if (subkey_out !== 48'hCB3D8B0E17F5 || subkey_valid !== 1'b1) begin bad++; $display("FAIL dec_r0 got=%h/%b exp=cb3d8b0e17f5/1", subkey_out, subkey_valid); end
    rd_mode = 1; rd_round = 15;
    step();
    total++; if (subkey_out !== 48'h1B02EFFC7072) begin bad++; $display("FAIL dec_r15 got=%h exp=1b02effc7072", subkey_out); end
    rd_req = 0;
    step();
    total++; if (subkey_valid !== 1'b0 || subkey_out !== 48'h1B02EFFC7072) begin bad++; $display("FAIL idle_hold got=%h/%b exp=1b02effc7072/0", subkey_out, subkey_valid); end
    for (int i = 0; i < 24; i++) begin
      rd_req = 1; rd_mode = 1'($urandom_range(0, 1)); rd_round = 4'($urandom_range(0, 15));
      exp_k = mdl[rd_mode ? 15 - int'(rd_round) : int'(rd_round)];
      step();
      total++; if (subkey_out !== exp_k || subkey_valid !== 1'b1 || rd_err !== 1'b0) begin bad++; $display("FAIL rand_read m=%b r=%0d got=%h exp=%h", rd_mode, rd_round, subkey_out, exp_k); end
    end
    rd_req = 0;
  endtask

  task automatic test_overflow();
    cd_valid = 1; c_in = 28'($urandom); d_in = 28'($urandom);
    rd_req = 1; rd_mode = 0; rd_round = 0;
    step();
    idle_inputs();
    total++; if (overflow !== 1'b1 || write_count !== 5'd16) begin bad++; $display("FAIL overflow got=%b/%0d exp=1/16", overflow, write_count); end
    total++; if (subkey_out !== 48'h1B02EFFC7072 || subkey_valid !== 1'b1) begin bad++; $display("FAIL overflow_slot0 got=%h exp=1b02effc7072", subkey_out); end
    step();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
    clear = 1; cd_valid = 1; c_in = 28'($urandom); d_in = 28'($urandom); rd_req = 1;
    step();
    idle_inputs();
    total++; if (overflow !== 1'b0 || keys_ready !== 1'b0 || write_count !== 5'd0) begin bad++; $display("FAIL clear got=%b/%b/%0d exp=0/0/0", overflow, keys_ready, write_count); end
    total++; if (subkey_valid !== 1'b0 || rd_err !== 1'b0) begin bad++; $display("FAIL clear_rd got=%b/%b exp=0/0", subkey_valid, rd_err); end
  endtask

  task automatic test_gapped_fill();
    logic [27:0] c, d;
    for (int r = 0; r < 16; r++) begin
      c = 28'($urandom); d = 28'($urandom);
      mdl[r] = pc2_ref(c, d);
      cd_valid = 1; c_in = c; d_in = d;
      step();
      idle_inputs();
      repeat ($urandom_range(0, 3)) step();
    end
    total++; if (keys_ready !== 1'b1 || write_count !== 5'd16) begin bad++; $display("FAIL gapped_full got=%b/%0d exp=1/16", keys_ready, write_count); end
    for (int i = 0; i < 16; i++) begin
      rd_req = 1; rd_mode = 0; rd_round = 4'(i);
      step();
      total++; if (subkey_out !== mdl[i] || $isunknown(subkey_out)) begin bad++; $display("FAIL gapped_slot%0d got=%h exp=%h", i, subkey_out, mdl[i]); end
    end
    rd_req = 0;
  endtask

  task automatic test_async_reset();
    clear = 1;
    step();
    clear = 0;
    for (int r = 0; r < 7; r++) begin
      cd_valid = 1; c_in = 28'($urandom); d_in = 28'($urandom);
      step();
      idle_inputs();
    end
    rd_req = 1; rd_round = 3;
    step();
    total++; if (rd_err !== 1'b1 || write_count !== 5'd7) begin bad++; $display("FAIL mid_fill got=%b/%0d exp=1/7", rd_err, write_count); end
    #2 rst_n = 0;
    #1;
    total++; if ({subkey_out, subkey_valid, rd_err, keys_ready, write_count, overflow} !== 57'd0) begin bad++; $display("FAIL async_reset got=%h exp=0", {subkey_out, subkey_valid, rd_err, keys_ready, write_count, overflow}); end
    rd_req = 0;
    #2 rst_n = 1;
    for (int r = 0; r < 16; r++) begin
      cd_valid = 1; c_in = kc[r]; d_in = kd[r];
      mdl[r] = pc2_ref(kc[r], kd[r]);
      step();
      idle_inputs();
      if (r == 0) begin
        total++; if (write_count !== 5'd1) begin bad++; $display("FAIL refill_first got=%0d exp=1", write_count); end
      end
    end
    total++; if (keys_ready !== 1'b1) begin bad++; $display("FAIL refill_ready got=%b exp=1", keys_ready); end
    for (int i = 0; i < 16; i++) begin
      rd_req = 1; rd_mode = 1; rd_round = 4'(i);
      step();
      total++; if (subkey_out !== mdl[15-i]) begin bad++; $display("FAIL refill_dec r=%0d got=%h exp=%h", i, subkey_out, mdl[15-i]); end
    end
    rd_req = 0;
  endtask

  initial begin
    build_schedule();
    test_reset();
    test_fill_known();
    test_read_known();
    test_overflow();
    test_gapped_fill();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
